// File: rtl/seq_comparator_if.sv
// Request/result bundle for seq_comparator: operands and start in, status and result flags out.
// A request is accepted on a rising edge where start=1 and busy=0; operands are captured then.
interface seq_comparator_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic             busy;
   logic             done;
   logic             gt;
   logic             eq;
   logic             lt;

   modport master (
      output start, signed_mode, data_a, data_b,
      input  busy, done, gt, eq, lt
   );

   modport slave (
      input  start, signed_mode, data_a, data_b,
      output busy, done, gt, eq, lt
   );
endinterface

// File: rtl/seq_comparator.sv
// Digit-serial magnitude comparator: walks operands MSD-first, DIGIT bits per cycle,
// and stops at the first differing digit. Signed mode flips the MSBs so signed order becomes unsigned order.
module seq_comparator #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   seq_comparator_if.slave     bus,
   output logic [1:0]          dbg_state
);
   localparam int N     = WIDTH / DIGIT;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [IDX_W-1:0]   idx;
   logic               gt_q;
   logic               eq_q;
   logic               lt_q;
   logic [DIGIT-1:0]   dig_a;
   logic [DIGIT-1:0]   dig_b;
   logic               differ;
   logic               last;
   logic               accept;

   // Captured operands shift left each step, so the digit under test is always the top one.
   assign dig_a  = a_q[WIDTH-1 -: DIGIT];
   assign dig_b  = b_q[WIDTH-1 -: DIGIT];
   assign differ = (dig_a != dig_b);
   assign last   = (idx == IDX_W'(N - 1));
   assign accept = bus.start && (state != S_RUN);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_RUN;
         S_RUN:   if (differ || last) state_nxt = S_DONE;
         S_DONE:  state_nxt = accept ? S_RUN : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (state)
         S_RUN:   bus.busy = 1'b1;
         S_DONE:  bus.done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: operand capture, digit stepping and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         idx  <= '0;
         gt_q <= 1'b0;
         eq_q <= 1'b0;
         lt_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  a_q <= {bus.data_a[WIDTH-1] ^ bus.signed_mode, bus.data_a[WIDTH-2:0]};
                  b_q <= {bus.data_b[WIDTH-1] ^ bus.signed_mode, bus.data_b[WIDTH-2:0]};
                  idx <= '0;
               end
            end
            S_RUN: begin
               if (differ) begin
                  gt_q <= (dig_a > dig_b);
                  lt_q <= (dig_a < dig_b);
                  eq_q <= 1'b0;
               end else if (last) begin
                  gt_q <= 1'b0;
                  lt_q <= 1'b0;
                  eq_q <= 1'b1;
               end else begin
                  idx <= idx + IDX_W'(1);
                  a_q <= a_q << DIGIT;
                  b_q <= b_q << DIGIT;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.gt    = gt_q;
   assign bus.eq    = eq_q;
   assign bus.lt    = lt_q;
   assign dbg_state = state;
endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator (WIDTH=16, DIGIT=4): vector table plus
// hand-written sequences for ignored start, mid-run reset and back-to-back requests.
module tb_seq_comparator;
   localparam int W = 16;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;

   seq_comparator_if #(.WIDTH(W)) bus ();

   seq_comparator #(.WIDTH(W), .DIGIT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   logic [2:0] exp_q[$];   // expected {gt, eq, lt} per launched comparison

   typedef struct {
      string      name;
      logic [15:0] a;
      logic [15:0] b;
      logic       sm;
      int         lat;
      logic [2:0] res;   // {gt, eq, lt}
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input string what,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %0h expected %0h", name, what, act, exp);
      end
   endtask

   // Driver: launch one comparison, then measure latency/busy and score the result.
   task automatic run_cmp(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input int exp_lat, input logic [2:0] exp_res);
      int cyc;
      int bcnt;
      logic [2:0] want;
      exp_q.push_back(exp_res);
      @(negedge clk);
      bus.start = 1'b1;
      bus.data_a = a;
      bus.data_b = b;
      bus.signed_mode = sm;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bcnt = int'(bus.busy);
      cyc = 0;
      while (!bus.done && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (!bus.done) bcnt += int'(bus.busy);
      end
      want = exp_q.pop_front();
      check(name, "latency", cyc, exp_lat);
      check(name, "busy_cycles", bcnt, exp_lat);
      check(name, "result_gel", {29'd0, bus.gt, bus.eq, bus.lt}, {29'd0, want});
   endtask

   initial begin
      int cyc;
      int seen_done;

      vecs[0] = '{"u_1234_1235", 16'h1234, 16'h1235, 1'b0, 4, 3'b001};
      vecs[1] = '{"u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 1, 3'b100};
      vecs[2] = '{"s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 1, 3'b001};
      vecs[3] = '{"u_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 4, 3'b010};
      vecs[4] = '{"s_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 4, 3'b010};
      vecs[5] = '{"u_1234_1200", 16'h1234, 16'h1200, 1'b0, 3, 3'b100};
      vecs[6] = '{"u_00f0_0100", 16'h00F0, 16'h0100, 1'b0, 2, 3'b001};
      vecs[7] = '{"s_fffe_ffff", 16'hFFFE, 16'hFFFF, 1'b1, 4, 3'b001};
      vecs[8] = '{"s_8000_8001", 16'h8000, 16'h8001, 1'b1, 4, 3'b001};
      vecs[9] = '{"s_0001_ffff", 16'h0001, 16'hFFFF, 1'b1, 1, 3'b100};

      bus.start = 1'b0;
      bus.signed_mode = 1'b0;
      bus.data_a = '0;
      bus.data_b = '0;
      rst_n = 1'b0;
      #1;
      check("reset", "outputs", {27'd0, bus.busy, bus.done, bus.gt, bus.eq, bus.lt}, 32'd0);
      check("reset", "state", {30'd0, dbg_state}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++)
         run_cmp(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].lat, vecs[i].res);

      // Start re-pulsed during RUN, operands also changed: must be ignored.
      @(negedge clk);
      bus.start = 1'b1;
      bus.data_a = 16'h1234;
      bus.data_b = 16'h1200;
      bus.signed_mode = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.data_a = 16'h0000;
      bus.data_b = 16'hFFFF;
      bus.signed_mode = 1'b1;
      cyc = 1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      while (!bus.done && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("ignored_start", "latency", cyc, 3);
      check("ignored_start", "result_gel", {29'd0, bus.gt, bus.eq, bus.lt}, 32'b100);

      // Reset during the second RUN cycle aborts with no done pulse.
      @(negedge clk);
      bus.start = 1'b1;
      bus.data_a = 16'hAAAA;
      bus.data_b = 16'hAAAA;
      bus.signed_mode = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #2;
      check("mid_reset", "busy_before", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_reset", "outputs", {27'd0, bus.busy, bus.done, bus.gt, bus.eq, bus.lt}, 32'd0);
      check("mid_reset", "state", {30'd0, dbg_state}, 32'd0);
      seen_done = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         seen_done += int'(bus.done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         seen_done += int'(bus.done);
      end
      check("mid_reset", "done_pulses", seen_done, 0);
      run_cmp("after_reset_5_5", 16'h0005, 16'h0005, 1'b0, 4, 3'b010);

      // Back-to-back: start held through DONE, new operands taken without an IDLE cycle.
      @(negedge clk);
      bus.start = 1'b1;
      bus.data_a = 16'h8000;
      bus.data_b = 16'h7FFF;
      bus.signed_mode = 1'b0;
      @(posedge clk);
      #1;
      cyc = 0;
      while (!bus.done && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("b2b_first", "latency", cyc, 1);
      check("b2b_first", "result_gel", {29'd0, bus.gt, bus.eq, bus.lt}, 32'b100);
      bus.data_a = 16'hFFFE;
      bus.data_b = 16'hFFFF;
      bus.signed_mode = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("b2b_second", "no_idle_state", {30'd0, dbg_state}, 32'd1);
      check("b2b_second", "held_result", {29'd0, bus.gt, bus.eq, bus.lt}, 32'b100);
      cyc = 0;
      while (!bus.done && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("b2b_second", "latency", cyc, 4);
      check("b2b_second", "result_gel", {29'd0, bus.gt, bus.eq, bus.lt}, 32'b001);
      @(posedge clk);
      #1;
      check("b2b_second", "idle_after", {30'd0, dbg_state}, 32'd0);
      check("b2b_second", "result_hold", {29'd0, bus.gt, bus.eq, bus.lt}, 32'b001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be >= 4.
REQ-002 Parameter DIGIT, default 4, bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT; N = WIDTH/DIGIT.
REQ-003 clk  input  1  rising-edge clock; sole clock of the block.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request a comparison; sampled on the rising edge of clk.
REQ-006 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured together with start.
REQ-007 data_a  input  WIDTH  operand A; captured when start is accepted.
REQ-008 data_b  input  WIDTH  operand B; captured when start is accepted.
REQ-009 busy  output  1  high while a comparison is in progress.
REQ-010 done  output  1  one-cycle pulse; result outputs are valid and updated.
REQ-011 gt  output  1  registered result, A > B.
REQ-012 eq  output  1  registered result, A == B.
REQ-013 lt  output  1  registered result, A < B.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
- IDLE -> RUN on accepted start.
- RUN -> DONE on decision.
- DONE -> RUN on accepted start, otherwise DONE -> IDLE.
REQ-015 start SHALL be accepted only when busy=0 (IDLE or DONE); start during RUN SHALL be ignored with no effect on operands or results.
REQ-016 On acceptance the block SHALL register:
- data_a and data_b, each with its MSB XORed with signed_mode, so that signed order maps to unsigned order;
- digit index i = 0 (most significant digit).
REQ-017 In RUN, each cycle the block SHALL compare digit i of the captured A and B, bits [WIDTH-1-DIGIT*i : WIDTH-DIGIT*(i+1)], as unsigned values.
REQ-018 If the digits differ, the block SHALL set gt/lt from that digit comparison, set eq=0 and enter DONE (early termination).
REQ-019 If the digits are equal and i < N-1, the block SHALL increment i and remain in RUN.
REQ-020 If the digits are equal and i = N-1, the block SHALL set eq=1, gt=0, lt=0 and enter DONE.
REQ-021 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-022 Latency: a decision at digit i SHALL assert done in the (i+1)th cycle after the accepting edge; worst case is N cycles (equal operands, or a difference only in the last digit).
REQ-023 gt, eq and lt SHALL change only at the edge entering DONE, and SHALL hold their values otherwise, including across a new start, until the next DONE.
REQ-024 Exactly one of gt/eq/lt SHALL be 1 after the first completed comparison.
REQ-025 Changes on data_a, data_b or signed_mode after acceptance SHALL NOT affect the comparison in progress.
REQ-026 start asserted during DONE SHALL be accepted, giving back-to-back operation with one DONE cycle between comparisons.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- busy=0, done=0, gt=0, eq=0, lt=0;
- captured operands and i to 0.
REQ-028 Reset asserted mid-RUN SHALL abort the comparison with no done pulse; the first start after rst_n rises SHALL be processed normally.

Verification (WIDTH=16, DIGIT=4)
REQ-029 Unsigned, A=0x1234, B=0x1235 -> busy high for 4 cycles; done in cycle 4; gt=0, eq=0, lt=1.
REQ-030 Unsigned, A=0x8000, B=0x7FFF -> done in cycle 1 (early exit); gt=1. Same operands with signed_mode=1 -> lt=1 (-32768 < 32767).
REQ-031 A=B=0xFFFF in both modes -> done in cycle 4; eq=1, gt=0, lt=0.
REQ-032 start re-pulsed with A=0, B=0xFFFF during RUN of a 0x1234-vs-0x1200 comparison -> request ignored; done in cycle 3 with gt=1.
REQ-033 rst_n pulsed low in cycle 2 of RUN -> all outputs 0 immediately and no done; a following start with A=5, B=5 -> eq=1 after 4 cycles.
REQ-034 Back-to-back: start held high across DONE with new operands A=0xFFFE, B=0xFFFF (signed) -> second comparison runs without an IDLE cycle; lt=1 after 4 cycles.
